vcve2_vec_seq: RTL and testbench

- Vector word sequencer sitting directly upstream of the vector-capable execute block.
- Accepts one decoded vector arithmetic instruction (vs1, vs2, vd, vl, vsew) and walks the destination register one 32-bit word at a time.
- For each word: reads packed element operands from the VRF, presents them to EX, waits for EX valid, then writes the result word back with tail byte-enables.
- Signals completion to the ID stage.

---
 rtl/vcve2_pkg.sv | 22 ++
 rtl/vcve2_vec_tail_be.sv | 26 ++
 rtl/vcve2_vec_seq.sv | 210 +++++++++++++++++++++
 tb/tb_vcve2_vec_seq.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vcve2_pkg.sv
// Shared types and helpers for the vector word sequencer and its byte-enable generator.
package vcve2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EXEC,
    ST_WB,
    ST_DONE,
    ST_ERR
  } vec_seq_state_e;

  localparam logic [2:0] VSEW_E8  = 3'b000;
  localparam logic [2:0] VSEW_E16 = 3'b001;
  localparam logic [2:0] VSEW_E32 = 3'b010;

  // Word address into the VRF: {5-bit register index, word index within register}.
  function automatic int vrf_word_addr_w(input int vlen);
    return 5 + $clog2(vlen / 32);
  endfunction

endpackage

// File: rtl/vcve2_vec_tail_be.sv
// Byte enables for one destination word: full word until the tail, then only the live bytes.
module vcve2_vec_tail_be #(
  parameter int TBW = 7,
  parameter int WIW = 2
) (
  input  logic [TBW-1:0] total_bytes_i,
  input  logic [WIW-1:0] word_idx_i,
  output logic [3:0]     be_o
);

  logic [TBW-1:0] rem;

  always_comb begin
    rem  = total_bytes_i - TBW'({word_idx_i, 2'b00});
    be_o = 4'hF;
    if (rem < TBW'(4)) begin
      case (rem[1:0])
        2'd0:    be_o = 4'b0000;
        2'd1:    be_o = 4'b0001;
        2'd2:    be_o = 4'b0011;
        default: be_o = 4'b0111;
      endcase
    end
  end

endmodule

// File: rtl/vcve2_vec_seq.sv
// Vector word sequencer: walks vd one 32-bit word at a time through VRF read, EX and write-back.
//
//   state | meaning
//   IDLE  | ready for a new instruction
//   READ  | read word_idx of vs1/vs2 into operand registers
//   EXEC  | operands presented to EX, waiting for ex_valid_i
//   WB    | write captured result to vd word_idx with tail byte-enables
//   DONE  | one-cycle completion pulse
//   ERR   | one-cycle illegal-configuration pulse
module vcve2_vec_seq
  import vcve2_pkg::*;
#(
  parameter int VLEN = 128,
  parameter int VLW  = $clog2(VLEN/8) + 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  output logic                              ready_o,
  input  logic                              kill_i,
  input  logic [VLW-1:0]                    vl_i,
  input  logic [2:0]                        vsew_i,
  input  logic [4:0]                        vs1_i,
  input  logic [4:0]                        vs2_i,
  input  logic [4:0]                        vd_i,
  output logic [vrf_word_addr_w(VLEN)-1:0]  vrf_raddr_a_o,
  output logic [vrf_word_addr_w(VLEN)-1:0]  vrf_raddr_b_o,
  input  logic [31:0]                       vrf_rdata_a_i,
  input  logic [31:0]                       vrf_rdata_b_i,
  output logic [31:0]                       ex_operand_a_o,
  output logic [31:0]                       ex_operand_b_o,
  output logic [2:0]                        ex_vsew_o,
  output logic                              ex_req_o,
  output logic                              ex_first_cycle_o,
  input  logic                              ex_valid_i,
  input  logic [31:0]                       ex_result_i,
  output logic                              vrf_we_o,
  output logic [vrf_word_addr_w(VLEN)-1:0]  vrf_waddr_o,
  output logic [31:0]                       vrf_wdata_o,
  output logic [3:0]                        vrf_wbe_o,
  output logic                              done_o,
  output logic                              error_o
);

  localparam int NW  = VLEN / 32;
  localparam int WIW = $clog2(NW);
  localparam int TBW = VLW + 2;
  localparam logic [TBW-1:0] MAX_BYTES = TBW'(VLEN / 8);

  vec_seq_state_e state_q, state_d;
  logic [TBW-1:0] total_bytes_q, total_bytes_d;
  logic [WIW-1:0] last_idx_q, last_idx_d;
  logic [WIW-1:0] word_idx_q, word_idx_d;
  logic [2:0]     vsew_q, vsew_d;
  logic [4:0]     vs1_q, vs1_d;
  logic [4:0]     vs2_q, vs2_d;
  logic [4:0]     vd_q, vd_d;
  logic [31:0]    op_a_q, op_a_d;
  logic [31:0]    op_b_q, op_b_d;
  logic [31:0]    result_q, result_d;
  logic           first_q, first_d;

  logic [TBW-1:0] vl_ext;
  logic [TBW-1:0] vl_max;
  logic [TBW-1:0] bytes_new;
  logic [TBW-1:0] nwords_new;
  logic           vsew_ok;
  logic [3:0]     tail_be;

  vcve2_vec_tail_be #(
    .TBW (TBW),
    .WIW (WIW)
  ) u_tail_be (
    .total_bytes_i (total_bytes_q),
    .word_idx_i    (word_idx_q),
    .be_o          (tail_be)
  );

  assign ex_operand_a_o   = op_a_q;
  assign ex_operand_b_o   = op_b_q;
  assign ex_vsew_o        = vsew_q;
  assign ex_first_cycle_o = first_q;

  always_comb begin
    vl_ext     = TBW'(vl_i);
    vsew_ok    = (vsew_i == VSEW_E8) || (vsew_i == VSEW_E16) || (vsew_i == VSEW_E32);
    vl_max     = MAX_BYTES >> vsew_i[1:0];
    bytes_new  = vl_ext << vsew_i[1:0];
    nwords_new = (bytes_new + TBW'(3)) >> 2;
  end

  always_comb begin
    state_d       = state_q;
    total_bytes_d = total_bytes_q;
    last_idx_d    = last_idx_q;
    word_idx_d    = word_idx_q;
    vsew_d        = vsew_q;
    vs1_d         = vs1_q;
    vs2_d         = vs2_q;
    vd_d          = vd_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    result_d      = result_q;
    first_d       = 1'b0;
    ready_o       = 1'b0;
    ex_req_o      = 1'b0;
    vrf_we_o      = 1'b0;
    vrf_raddr_a_o = '0;
    vrf_raddr_b_o = '0;
    vrf_waddr_o   = '0;
    vrf_wdata_o   = '0;
    vrf_wbe_o     = '0;
    done_o        = 1'b0;
    error_o       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (start_i && !kill_i) begin
          total_bytes_d = bytes_new;
          last_idx_d    = WIW'(nwords_new - TBW'(1));
          word_idx_d    = '0;
          vsew_d        = vsew_i;
          vs1_d         = vs1_i;
          vs2_d         = vs2_i;
          vd_d          = vd_i;
          if (!vsew_ok || (vl_ext > vl_max)) state_d = ST_ERR;
          else if (vl_i == '0)              state_d = ST_DONE;
          else                              state_d = ST_READ;
        end
      end
      ST_READ: begin
        vrf_raddr_a_o = {vs1_q, word_idx_q};
        vrf_raddr_b_o = {vs2_q, word_idx_q};
        op_a_d        = vrf_rdata_a_i;
        op_b_d        = vrf_rdata_b_i;
        first_d       = 1'b1;
        state_d       = ST_EXEC;
      end
      ST_EXEC: begin
        ex_req_o = 1'b1;
        if (ex_valid_i) begin
          result_d = ex_result_i;
          state_d  = ST_WB;
        end
      end
      ST_WB: begin
        vrf_we_o    = 1'b1;
        vrf_waddr_o = {vd_q, word_idx_q};
        vrf_wdata_o = result_q;
        vrf_wbe_o   = tail_be;
        if (word_idx_q == last_idx_q) begin
          state_d = ST_DONE;
        end else begin
          word_idx_d = word_idx_q + WIW'(1);
          state_d    = ST_READ;
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR: begin
        error_o = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Flush overrides everything, including a write-back already on the bus this cycle.
    if (kill_i) begin
      state_d  = ST_IDLE;
      first_d  = 1'b0;
      vrf_we_o = 1'b0;
      done_o   = 1'b0;
      error_o  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      total_bytes_q <= '0;
      last_idx_q    <= '0;
      word_idx_q    <= '0;
      vsew_q        <= '0;
      vs1_q         <= '0;
      vs2_q         <= '0;
      vd_q          <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      result_q      <= '0;
      first_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      total_bytes_q <= total_bytes_d;
      last_idx_q    <= last_idx_d;
      word_idx_q    <= word_idx_d;
      vsew_q        <= vsew_d;
      vs1_q         <= vs1_d;
      vs2_q         <= vs2_d;
      vd_q          <= vd_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      result_q      <= result_d;
      first_q       <= first_d;
    end
  end

endmodule

// File: tb/tb_vcve2_vec_seq.sv
// Scoreboard bench for vcve2_vec_seq: directed ops, expected operands/writes queued, monitor compares.
module tb_vcve2_vec_seq;

  localparam int VLEN = 128;
  localparam int VLW  = 5;
  localparam int AW   = 7;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           start_i;
  logic           ready_o;
  logic           kill_i;
  logic [VLW-1:0] vl_i;
  logic [2:0]     vsew_i;
  logic [4:0]     vs1_i, vs2_i, vd_i;
  logic [AW-1:0]  vrf_raddr_a_o, vrf_raddr_b_o;
  logic [31:0]    vrf_rdata_a_i, vrf_rdata_b_i;
  logic [31:0]    ex_operand_a_o, ex_operand_b_o;
  logic [2:0]     ex_vsew_o;
  logic           ex_req_o, ex_first_cycle_o, ex_valid_i;
  logic [31:0]    ex_result_i;
  logic           vrf_we_o;
  logic [AW-1:0]  vrf_waddr_o;
  logic [31:0]    vrf_wdata_o;
  logic [3:0]     vrf_wbe_o;
  logic           done_o, error_o;

  vcve2_vec_seq #(.VLEN(VLEN), .VLW(VLW)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .start_i          (start_i),
    .ready_o          (ready_o),
    .kill_i           (kill_i),
    .vl_i             (vl_i),
    .vsew_i           (vsew_i),
    .vs1_i            (vs1_i),
    .vs2_i            (vs2_i),
    .vd_i             (vd_i),
    .vrf_raddr_a_o    (vrf_raddr_a_o),
    .vrf_raddr_b_o    (vrf_raddr_b_o),
    .vrf_rdata_a_i    (vrf_rdata_a_i),
    .vrf_rdata_b_i    (vrf_rdata_b_i),
    .ex_operand_a_o   (ex_operand_a_o),
    .ex_operand_b_o   (ex_operand_b_o),
    .ex_vsew_o        (ex_vsew_o),
    .ex_req_o         (ex_req_o),
    .ex_first_cycle_o (ex_first_cycle_o),
    .ex_valid_i       (ex_valid_i),
    .ex_result_i      (ex_result_i),
    .vrf_we_o         (vrf_we_o),
    .vrf_waddr_o      (vrf_waddr_o),
    .vrf_wdata_o      (vrf_wdata_o),
    .vrf_wbe_o        (vrf_wbe_o),
    .done_o           (done_o),
    .error_o          (error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    be;
  } wr_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  sew;
  } op_t;

  wr_t wq[$];
  op_t oq[$];
  op_t cur_op;

  int n_checks  = 0;
  int n_errs    = 0;
  int done_cnt  = 0;
  int err_cnt   = 0;
  int first_cnt = 0;
  int stall_cfg = 0;
  int ex_cnt;

  function automatic logic [31:0] rd_a(input logic [AW-1:0] a);
    return 32'h1100_0000 + 32'(a);
  endfunction

  function automatic logic [31:0] rd_b(input logic [AW-1:0] a);
    return 32'h0022_0000 + (32'(a) << 8);
  endfunction

  assign vrf_rdata_a_i = rd_a(vrf_raddr_a_o);
  assign vrf_rdata_b_i = rd_b(vrf_raddr_b_o);

  // EX stub: result is a + b, returned after stall_cfg extra cycles in EXEC.
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i)         ex_cnt <= 0;
    else if (ex_req_o) ex_cnt <= ex_cnt + 1;
    else               ex_cnt <= 0;
  end
  assign ex_valid_i  = ex_req_o && (ex_cnt >= stall_cfg);
  assign ex_result_i = ex_operand_a_o + ex_operand_b_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    n_checks++;
    n_errs++;
    $display("FAIL %s: got %h expected none", name, act);
  endtask

  initial begin : monitor
    wr_t w;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        if (done_o)  done_cnt++;
        if (error_o) err_cnt++;
        if (ex_first_cycle_o) begin
          first_cnt++;
          if (oq.size() == 0) fail_now("unexpected_exec", ex_operand_a_o);
          else cur_op = oq.pop_front();
        end
        if (ex_req_o) begin
          chk("ex_operand_a", ex_operand_a_o, cur_op.a);
          chk("ex_operand_b", ex_operand_b_o, cur_op.b);
          chk("ex_vsew", 32'(ex_vsew_o), 32'(cur_op.sew));
        end
        if (vrf_we_o) begin
          if (wq.size() == 0) fail_now("unexpected_write", 32'(vrf_waddr_o));
          else begin
            w = wq.pop_front();
            chk("wb_addr", 32'(vrf_waddr_o), 32'(w.addr));
            chk("wb_data", vrf_wdata_o, w.data);
            chk("wb_be", 32'(vrf_wbe_o), 32'(w.be));
          end
        end
      end
    end
  end

  task automatic push_word(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                           input int w, input logic [2:0] sew, input logic [3:0] be,
                           input bit with_wr);
    logic [AW-1:0] aa, ab, ad;
    op_t o;
    wr_t r;
    aa = {s1, 2'(w)};
    ab = {s2, 2'(w)};
    ad = {d, 2'(w)};
    o.a = rd_a(aa);
    o.b = rd_b(ab);
    o.sew = sew;
    oq.push_back(o);
    if (with_wr) begin
      r.addr = ad;
      r.data = rd_a(aa) + rd_b(ab);
      r.be   = be;
      wq.push_back(r);
    end
  endtask

  // bes: hand-computed byte enables per word, word 0 in bits [3:0].
  task automatic run_op(input string name, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [4:0] d, input logic [VLW-1:0] vl, input logic [2:0] sew,
                        input int stall, input int nw, input logic [15:0] bes,
                        input bit exp_err, input int exp_lat, input bit exact);
    int n, d0, e0, f0;
    bit got_err;
    stall_cfg = stall;
    for (int w = 0; w < nw; w++) push_word(s1, s2, d, w, sew, bes[4*w +: 4], 1'b1);
    d0 = done_cnt; e0 = err_cnt; f0 = first_cnt;
    vs1_i = s1; vs2_i = s2; vd_i = d; vl_i = vl; vsew_i = sew;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    n = 0;
    got_err = 1'b0;
    while (n < 300) begin
      @(negedge clk_i);
      n++;
      if (done_o || error_o) begin
        got_err = error_o;
        break;
      end
    end
    if (n >= 300) fail_now({name, "_timeout"}, 32'(n));
    chk({name, "_err_kind"}, 32'(got_err), 32'(exp_err));
    if (exact) chk({name, "_latency"}, 32'(n), 32'(exp_lat));
    else       chk({name, "_latency_max"}, 32'(n <= exp_lat), 32'd1);
    @(posedge clk_i); #1;
    chk({name, "_ready"}, 32'(ready_o), 32'd1);
    chk({name, "_done_pulses"}, 32'(done_cnt - d0), 32'(!exp_err));
    chk({name, "_err_pulses"}, 32'(err_cnt - e0), 32'(exp_err));
    chk({name, "_first_cycles"}, 32'(first_cnt - f0), 32'(nw));
    chk({name, "_wq_empty"}, 32'(wq.size()), 32'd0);
    chk({name, "_oq_empty"}, 32'(oq.size()), 32'd0);
  endtask

  initial begin : stim
    int d0, e0;
    rst_i = 1'b1; start_i = 1'b0; kill_i = 1'b0;
    vl_i = '0; vsew_i = '0; vs1_i = '0; vs2_i = '0; vd_i = '0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_we", 32'(vrf_we_o), 32'd0);
    chk("rst_ex_req", 32'(ex_req_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);
    chk("rst_op_a", ex_operand_a_o, 32'd0);
    chk("rst_raddr_a", 32'(vrf_raddr_a_o), 32'd0);
    chk("rst_ex_vsew", 32'(ex_vsew_o), 32'd0);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    run_op("e32_vl4",    5'd1,  5'd2,  5'd3,  5'd4,  3'b010, 0, 4, 16'hFFFF, 1'b0, 13, 1'b1);
    run_op("e8_vl6",     5'd4,  5'd5,  5'd6,  5'd6,  3'b000, 0, 2, 16'h003F, 1'b0, 7,  1'b1);
    run_op("e16_vl3_st", 5'd7,  5'd8,  5'd9,  5'd3,  3'b001, 4, 2, 16'h003F, 1'b0, 15, 1'b1);
    run_op("vl0",        5'd1,  5'd1,  5'd1,  5'd0,  3'b000, 0, 0, 16'h0000, 1'b0, 2,  1'b0);
    run_op("sew_illegal",5'd1,  5'd2,  5'd3,  5'd2,  3'b011, 0, 0, 16'h0000, 1'b1, 1,  1'b1);
    run_op("e32_vl5",    5'd1,  5'd2,  5'd3,  5'd5,  3'b010, 0, 0, 16'h0000, 1'b1, 1,  1'b1);
    run_op("e8_vl16_ip", 5'd10, 5'd11, 5'd10, 5'd16, 3'b000, 0, 4, 16'hFFFF, 1'b0, 13, 1'b1);
    run_op("e16_vl8",    5'd12, 5'd13, 5'd14, 5'd8,  3'b001, 0, 4, 16'hFFFF, 1'b0, 13, 1'b1);

    // Kill in the write-back of word 1: word 0 written, word 1 suppressed, no done.
    stall_cfg = 0;
    push_word(5'd20, 5'd21, 5'd22, 0, 3'b010, 4'hF, 1'b1);
    push_word(5'd20, 5'd21, 5'd22, 1, 3'b010, 4'hF, 1'b0);
    d0 = done_cnt; e0 = err_cnt;
    vs1_i = 5'd20; vs2_i = 5'd21; vd_i = 5'd22; vl_i = 5'd4; vsew_i = 3'b010;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    repeat (5) @(posedge clk_i);
    #1;
    chk("kill_pre_we", 32'(vrf_we_o), 32'd1);
    kill_i = 1'b1;
    #1;
    chk("kill_we_masked", 32'(vrf_we_o), 32'd0);
    @(posedge clk_i); #1;
    kill_i = 1'b0;
    chk("kill_ready", 32'(ready_o), 32'd1);
    repeat (5) @(negedge clk_i);
    chk("kill_no_done", 32'(done_cnt - d0), 32'd0);
    chk("kill_no_err", 32'(err_cnt - e0), 32'd0);
    chk("kill_wq_empty", 32'(wq.size()), 32'd0);
    chk("kill_oq_empty", 32'(oq.size()), 32'd0);
    @(posedge clk_i); #1;
    run_op("after_kill", 5'd2, 5'd3, 5'd4, 5'd4, 3'b010, 0, 4, 16'hFFFF, 1'b0, 13, 1'b1);

    // Asynchronous reset in the middle of EXEC: immediate idle outputs, no write afterwards.
    stall_cfg = 4;
    push_word(5'd24, 5'd25, 5'd26, 0, 3'b010, 4'hF, 1'b0);
    d0 = done_cnt;
    vs1_i = 5'd24; vs2_i = 5'd25; vd_i = 5'd26; vl_i = 5'd4; vsew_i = 3'b010;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    #2;
    chk("rst_mid_ex_req_pre", 32'(ex_req_o), 32'd1);
    rst_i = 1'b1;
    #1;
    chk("rst_mid_ready", 32'(ready_o), 32'd1);
    chk("rst_mid_ex_req", 32'(ex_req_o), 32'd0);
    chk("rst_mid_op_a", ex_operand_a_o, 32'd0);
    chk("rst_mid_first", 32'(ex_first_cycle_o), 32'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    repeat (12) @(negedge clk_i);
    chk("rst_mid_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rst_mid_wq_empty", 32'(wq.size()), 32'd0);
    chk("rst_mid_oq_empty", 32'(oq.size()), 32'd0);
    @(posedge clk_i); #1;
    run_op("after_rst", 5'd3, 5'd4, 5'd5, 5'd6, 3'b000, 0, 2, 16'h003F, 1'b0, 7, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errs);
    $fatal(1, "watchdog");
  end

endmodule
